mtimer_sched: RTL
=================

Name: mtimer_sched

Overview:
- AXI master-side scheduler that multiplexes N software deadline slots onto the single 64-bit mtimercmp register of the machine-timer slave (mtimercmp low word at BASE_ADDR+0x8, high word at +0xC).
- Keeps a slot table, programs the timer with the earliest valid deadline through glitch-safe three-write sequences, and turns mtimer_irq into per-slot expiry pulses.
- Sits between the CPU-side timer service logic and the timer's AXI slave port.

Parameters:
- N_SLOTS, 4, number of deadline slots (2..8).
- BASE_ADDR, 32'h0, byte base address of the timer slave.
- AXI_TID, 0, ID driven on awid/arid.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- arm_valid_i  in  1  arm request
- arm_ready_o  out  1  arm accepted when arm_valid_i && arm_ready_o
- arm_slot_i  in  $clog2(N_SLOTS)  slot index
- arm_time_i  in  64  absolute deadline
- cancel_i  in  N_SLOTS  per-slot cancel, level, sampled each cycle
- mtimer_irq_i  in  1  timer interrupt (mtime >= mtimercmp)
- expired_o  out  N_SLOTS  one-cycle expiry pulse per slot
- pending_o  out  N_SLOTS  slot valid flags
- busy_o  out  1  programming sequence in flight
- err_o  out  1  sticky: a non-OKAY bresp was received
- axi_mosi  out  s_axi_mosi_t  master request (AW/W/B only)
- axi_miso  in  s_axi_miso_t  slave response

Behaviour:
- Reset (rst low at posedge):
  - valid[] = 0; cur_cmp_ff = 64'hFFFF_FFFF_FFFF_FFFF (matches timer reset).
  - State IDLE.
  - expired_o = pending_o = busy_o = err_o = 0; all axi_mosi fields 0.
  - Reset mid-sequence abandons the transaction; the timer is reset by the same rst.
- Static AXI fields: awlen=0, awsize=2, awburst=INCR, wstrb=4'hF, wlast=1, awid=AXI_TID, bready=1, arvalid=0, rready=0.
- arm_ready_o = (state==IDLE).
- Slot table update:
  - Accepted arm sets valid[slot] and deadline[slot] = arm_time_i; re-arming overwrites.
  - cancel_i[k] clears valid[k] in any state.
  - Cancel wins over a same-cycle arm of the same slot.
- target: minimum deadline over valid slots, unsigned 64-bit compare; all-ones if no slot is valid.
- IDLE priority, one action per cycle:
  1. If mtimer_irq_i and any valid slot has deadline <= cur_cmp_ff:
     - pulse expired_o for exactly those slots and clear their valid bits;
     - no reprogram this cycle.
  2. Else if target != cur_cmp_ff: latch tgt_ff = target, go to WR0.
  3. mtimer_irq_i with no matching slot is ignored.
- Sequence states: WR0 (addr +0x8, data 32'hFFFF_FFFF) -> WR1 (+0xC, tgt[63:32]) -> WR2 (+0x8, tgt[31:0]).
- Each write:
  - On state entry, awvalid=1 and wvalid=1 together.
  - Each valid drops independently on its handshake (awready / wready). wvalid must not wait for wready, because the slave raises wready only after the AW handshake.
  - After both handshakes, wait for bvalid.
  - On B: if bresp!=OKAY, set err_o; advance regardless.
- WR2 B completion: cur_cmp_ff <= tgt_ff, return to IDLE. The IDLE check in the following cycle reprograms if the table changed meanwhile.
- Guard rationale: the programmed compare value never drops below min(old, new) at any point, so no spurious early IRQ is produced.
  - mtimer_irq_i is ignored outside IDLE.
  - A single write completes in 3 cycles minimum with the reference timer slave; a full reprogram takes ~9 cycles.
- busy_o = (state != IDLE). pending_o = valid[].
- A deadline already in the past is programmed normally; IRQ rises and the slot expires in the first IDLE cycle after WR2.
- Expiry uses <=, so all slots with deadline equal to the minimum expire in the same pulse.

Test Plan:
- Reset, then idle 20 cycles -> no AXI traffic, cur_cmp all-ones, pending=0, arm_ready=1.
- Arm slot0 @ 64'h0000_0001_0000_0100 -> three writes in order: +0x8=FFFFFFFF, +0xC=00000001, +0x8=00000100; busy high throughout; then timer cmp reads 0x1_0000_0100.
- Arm slot1=500, then slot2=300 (timer counting from 0):
  - program 500, then reprogram 300;
  - expired_o=4'b0100 pulse near mtime 300, then reprogram 500;
  - expired_o=4'b0010 near mtime 500, then reprogram all-ones.
- Arm slot0=1000 and slot3=1000 -> single expired_o=4'b1001 pulse.
- Arm slot1=2000, cancel slot1 during WR1 -> sequence completes, then reprograms to all-ones; no expiry pulse.
- Slave returns bresp=SLVERR on WR0 -> err_o sticks at 1, sequence still finishes WR1/WR2; arm_slot=slot0 with deadline 10 (already past) -> immediate expiry after WR2.

Source files
------------

// File: rtl/mtimer_sched.sv
// mtimer_sched: multiplexes N deadline slots onto the single 64-bit mtimercmp
// register of a machine-timer AXI slave. The compare value is always updated
// low-word-to-all-ones first, then the high word, then the low word, so it never
// transiently falls below min(old, new) and cannot raise an early interrupt.

package mtimer_sched_pkg;
   typedef struct packed {
      logic [3:0]  awid;
      logic [31:0] awaddr;
      logic [7:0]  awlen;
      logic [2:0]  awsize;
      logic [1:0]  awburst;
      logic        awvalid;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        wlast;
      logic        wvalid;
      logic        bready;
      logic        arvalid;
      logic        rready;
   } s_axi_mosi_t;

   typedef struct packed {
      logic        awready;
      logic        wready;
      logic [1:0]  bresp;
      logic        bvalid;
   } s_axi_miso_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
endpackage

module mtimer_sched
   import mtimer_sched_pkg::*;
#(
   parameter int          N_SLOTS   = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter logic [3:0]  AXI_TID   = 4'h0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       arm_valid_i,
   output logic                       arm_ready_o,
   input  logic [$clog2(N_SLOTS)-1:0] arm_slot_i,
   input  logic [63:0]                arm_time_i,
   input  logic [N_SLOTS-1:0]         cancel_i,
   input  logic                       mtimer_irq_i,
   output logic [N_SLOTS-1:0]         expired_o,
   output logic [N_SLOTS-1:0]         pending_o,
   output logic                       busy_o,
   output logic                       err_o,
   output s_axi_mosi_t                axi_mosi,
   input  s_axi_miso_t                axi_miso
);

   localparam int             SW         = $clog2(N_SLOTS);
   localparam logic [SW:0]    SLOT_LIMIT = (SW+1)'(N_SLOTS);
   localparam logic [63:0]    CMP_MAX    = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [1:0] {ST_IDLE, ST_WR0, ST_WR1, ST_WR2} state_t;

   state_t               state_r, state_s;
   logic [N_SLOTS-1:0]   valid_r, valid_s;
   logic [63:0]          deadline_r [N_SLOTS];
   logic [63:0]          deadline_s [N_SLOTS];
   logic [63:0]          cur_cmp_r, cur_cmp_s;
   logic [63:0]          tgt_r, tgt_s;
   logic                 aw_done_r, aw_done_s;
   logic                 w_done_r, w_done_s;
   logic                 err_r, err_s;
   logic [N_SLOTS-1:0]   expired_r, expired_s;
   s_axi_mosi_t          mosi_r, mosi_s;

   logic [63:0]          target_s;
   logic [N_SLOTS-1:0]   due_s;
   logic                 arm_fire_s;
   logic                 b_fire_s;

   assign arm_fire_s = arm_valid_i && (state_r == ST_IDLE) && ({1'b0, arm_slot_i} < SLOT_LIMIT);
   // The response only counts once both request channels of this write have handshaken.
   assign b_fire_s   = aw_done_r && w_done_r && axi_miso.bvalid;

   // Earliest valid deadline, and slots already covered by the programmed compare value.
   always_comb begin
      target_s = CMP_MAX;
      due_s    = '0;
      for (int k = 0; k < N_SLOTS; k++) begin
         target_s = (valid_r[k] && (deadline_r[k] < target_s)) ? deadline_r[k] : target_s;
         due_s[k] = valid_r[k] && (deadline_r[k] <= cur_cmp_r);
      end
   end

   // Next-state, slot table and write-sequence control.
   always_comb begin
      state_s    = state_r;
      valid_s    = valid_r;
      deadline_s = deadline_r;
      cur_cmp_s  = cur_cmp_r;
      tgt_s      = tgt_r;
      err_s      = err_r;
      expired_s  = '0;
      aw_done_s  = aw_done_r | (mosi_r.awvalid & axi_miso.awready);
      w_done_s   = w_done_r  | (mosi_r.wvalid  & axi_miso.wready);

      case (state_r)
         ST_IDLE: begin
            if (mtimer_irq_i && (due_s != '0)) begin
               expired_s = due_s;
               valid_s   = valid_r & ~due_s;
            end else if (target_s != cur_cmp_r) begin
               tgt_s     = target_s;
               state_s   = ST_WR0;
               aw_done_s = 1'b0;
               w_done_s  = 1'b0;
            end else begin
               state_s   = ST_IDLE;
            end
            // A re-arm lands after the expiry clear so a fresh deadline survives.
            if (arm_fire_s) begin
               valid_s[arm_slot_i]    = 1'b1;
               deadline_s[arm_slot_i] = arm_time_i;
            end else begin
               valid_s = valid_s;
            end
         end
         ST_WR0: begin
            if (b_fire_s) begin
               err_s     = err_r | (axi_miso.bresp != AXI_RESP_OKAY);
               state_s   = ST_WR1;
               aw_done_s = 1'b0;
               w_done_s  = 1'b0;
            end else begin
               state_s   = ST_WR0;
            end
         end
         ST_WR1: begin
            if (b_fire_s) begin
               err_s     = err_r | (axi_miso.bresp != AXI_RESP_OKAY);
               state_s   = ST_WR2;
               aw_done_s = 1'b0;
               w_done_s  = 1'b0;
            end else begin
               state_s   = ST_WR1;
            end
         end
         ST_WR2: begin
            if (b_fire_s) begin
               err_s     = err_r | (axi_miso.bresp != AXI_RESP_OKAY);
               cur_cmp_s = tgt_r;
               state_s   = ST_IDLE;
               aw_done_s = 1'b0;
               w_done_s  = 1'b0;
            end else begin
               state_s   = ST_WR2;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // Cancel overrides everything, including a same-cycle arm.
      valid_s = valid_s & ~cancel_i;
   end

   // AXI request for the next cycle, derived from the next sequence state.
   always_comb begin
      mosi_s         = '0;
      mosi_s.awid    = AXI_TID;
      mosi_s.awlen   = 8'd0;
      mosi_s.awsize  = 3'd2;
      mosi_s.awburst = AXI_BURST_INCR;
      mosi_s.wstrb   = 4'hF;
      mosi_s.wlast   = 1'b1;
      mosi_s.bready  = 1'b1;
      mosi_s.arvalid = 1'b0;
      mosi_s.rready  = 1'b0;
      mosi_s.awvalid = (state_s != ST_IDLE) && !aw_done_s;
      mosi_s.wvalid  = (state_s != ST_IDLE) && !w_done_s;
      case (state_s)
         ST_WR0: begin
            mosi_s.awaddr = BASE_ADDR + 32'h8;
            mosi_s.wdata  = 32'hFFFF_FFFF;
         end
         ST_WR1: begin
            mosi_s.awaddr = BASE_ADDR + 32'hC;
            mosi_s.wdata  = tgt_s[63:32];
         end
         ST_WR2: begin
            mosi_s.awaddr = BASE_ADDR + 32'h8;
            mosi_s.wdata  = tgt_s[31:0];
         end
         default: begin
            mosi_s.awaddr = 32'h0;
            mosi_s.wdata  = 32'h0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         valid_r   <= '0;
         for (int k = 0; k < N_SLOTS; k++) begin
            deadline_r[k] <= 64'h0;
         end
         cur_cmp_r <= CMP_MAX;
         tgt_r     <= CMP_MAX;
         aw_done_r <= 1'b0;
         w_done_r  <= 1'b0;
         err_r     <= 1'b0;
         expired_r <= '0;
         mosi_r    <= '0;
      end else begin
         state_r    <= state_s;
         valid_r    <= valid_s;
         deadline_r <= deadline_s;
         cur_cmp_r  <= cur_cmp_s;
         tgt_r      <= tgt_s;
         aw_done_r  <= aw_done_s;
         w_done_r   <= w_done_s;
         err_r      <= err_s;
         expired_r  <= expired_s;
         mosi_r     <= mosi_s;
      end
   end

   assign arm_ready_o = (state_r == ST_IDLE);
   assign busy_o      = (state_r != ST_IDLE);
   assign pending_o   = valid_r;
   assign expired_o   = expired_r;
   assign err_o       = err_r;
   assign axi_mosi    = mosi_r;

endmodule
